// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: op codes, FSM states, default width.
// Optional build macro MDU_FAST_MUL_EN is consumed by mul_div_unit.
package mdu_pkg;

    localparam int MDU_DATA_W = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mdu_div_core.sv
// Restoring-division datapath on unsigned magnitudes: one quotient bit per step,
// DATA_W steps after load yield quotient and remainder.
module mdu_div_core #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic              step,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    logic [DATA_W-1:0] dvs_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W:0]   trial;

    // MSB of the trial difference is the borrow: set means the divisor did not fit
    assign trial = {rem_q, quo_q[DATA_W-1]} - {1'b0, dvs_q};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dvs_q <= '0;
            quo_q <= '0;
            rem_q <= '0;
        end else if (load) begin
            dvs_q <= divisor;
            quo_q <= dividend;
            rem_q <= '0;
        end else if (step) begin
            if (!trial[DATA_W]) begin
                rem_q <= trial[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end else begin
                rem_q <= {rem_q[DATA_W-2:0], quo_q[DATA_W-1]};
                quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning HI/LO, with start/cancel handshake.
// Define MDU_FAST_MUL_EN for a single-cycle combinational multiplier.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int DATA_W = MDU_DATA_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start_i,
    input  logic [1:0]        op_i,
    input  logic [DATA_W-1:0] src_a_i,
    input  logic [DATA_W-1:0] src_b_i,
    input  logic              cancel_i,
    input  logic              hi_we_i,
    input  logic              lo_we_i,
    input  logic [DATA_W-1:0] hilo_wdata_i,
    output logic              busy_o,
    output logic              stall_o,
    output logic              done_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;

    mdu_state_e state, state_nxt;

    logic                  launch;
    logic                  is_div_in, is_signed_in, a_neg, b_neg;
    logic [DATA_W-1:0]     abs_a, abs_b;

    logic                  is_div_q, neg_res, neg_rem, div_zero;
    logic [DATA_W-1:0]     mag_a, dvd_raw;
    logic [CNT_W-1:0]      cnt;
    logic [2*DATA_W-1:0]   prod, prod_fix;
    logic                  fast_mul, last_step;

    logic [DATA_W-1:0]     quo, rem;
    logic [DATA_W-1:0]     res_hi, res_lo;
    logic [DATA_W-1:0]     hi_q, lo_q;

    assign launch       = (state == IDLE) && start_i && !cancel_i;
    assign is_div_in    = (op_i == MDU_DIV) || (op_i == MDU_DIVU);
    assign is_signed_in = (op_i == MDU_MULT) || (op_i == MDU_DIV);
    assign a_neg        = is_signed_in && src_a_i[DATA_W-1];
    assign b_neg        = is_signed_in && src_b_i[DATA_W-1];
    assign abs_a        = a_neg ? -src_a_i : src_a_i;
    assign abs_b        = b_neg ? -src_b_i : src_b_i;

`ifdef MDU_FAST_MUL_EN
    assign fast_mul = !is_div_q;
`else
    assign fast_mul = 1'b0;
`endif
    assign last_step = fast_mul || (cnt == CNT_W'(1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start_i) state_nxt = BUSY;
            BUSY:    if (last_step) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (cancel_i) state_nxt = IDLE;
    end

    // Operand magnitudes and result signs are frozen at launch
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            is_div_q <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            mag_a    <= '0;
            dvd_raw  <= '0;
            cnt      <= '0;
        end else if (launch) begin
            is_div_q <= is_div_in;
            neg_res  <= a_neg ^ b_neg;
            neg_rem  <= a_neg;
            div_zero <= is_div_in && (src_b_i == '0);
            mag_a    <= abs_a;
            dvd_raw  <= src_a_i;
            cnt      <= CNT_W'(DATA_W);
        end else if (state == BUSY) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

`ifndef MDU_FAST_MUL_EN
    logic [DATA_W:0] add_sum;
    assign add_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + (prod[0] ? {1'b0, mag_a} : '0);
`endif

    // Low half of prod starts as the multiplier and is consumed one bit per step
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            prod <= '0;
        end else if (launch) begin
            prod <= {{DATA_W{1'b0}}, abs_b};
        end else if (state == BUSY && !is_div_q) begin
`ifdef MDU_FAST_MUL_EN
            prod <= (2*DATA_W)'(mag_a) * (2*DATA_W)'(prod[DATA_W-1:0]);
`else
            prod <= {add_sum, prod[DATA_W-1:1]};
`endif
        end
    end

    mdu_div_core #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .resetn    (resetn),
        .load      (launch),
        .step      ((state == BUSY) && is_div_q),
        .dividend  (abs_a),
        .divisor   (abs_b),
        .quotient  (quo),
        .remainder (rem)
    );

    assign prod_fix = neg_res ? -prod : prod;

    always_comb begin
        res_hi = prod_fix[2*DATA_W-1:DATA_W];
        res_lo = prod_fix[DATA_W-1:0];
        if (is_div_q) begin
            if (div_zero) begin
                res_hi = dvd_raw;
                res_lo = '1;
            end else begin
                res_hi = neg_rem ? -rem : rem;
                res_lo = neg_res ? -quo : quo;
            end
        end
    end

    // Completed result overrides MTHI/MTLO; a cancelled DONE falls back to them
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (state == DONE && !cancel_i) begin
            hi_q <= res_hi;
            lo_q <= res_lo;
        end else begin
            if (hi_we_i) hi_q <= hilo_wdata_i;
            if (lo_we_i) lo_q <= hilo_wdata_i;
        end
    end

    assign busy_o  = (state == BUSY);
    assign stall_o = launch || (state == BUSY);
    assign done_o  = (state == DONE);
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_mul_div_unit;

    localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = W + 1;
`endif

    logic          clk = 1'b0;
    logic          resetn;
    logic          start_i, cancel_i, hi_we_i, lo_we_i;
    logic [1:0]    op_i;
    logic [W-1:0]  src_a_i, src_b_i, hilo_wdata_i;
    logic          busy_o, stall_o, done_o;
    logic [W-1:0]  hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.DATA_W(W)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .start_i      (start_i),
        .op_i         (op_i),
        .src_a_i      (src_a_i),
        .src_b_i      (src_b_i),
        .cancel_i     (cancel_i),
        .hi_we_i      (hi_we_i),
        .lo_we_i      (lo_we_i),
        .hilo_wdata_i (hilo_wdata_i),
        .busy_o       (busy_o),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
        int           mode;
    } vec_t;

    vec_t vt[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // MIPS HI/LO semantics from plain integer arithmetic
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a, b,
                                  output logic [W-1:0] hi, output logic [W-1:0] lo);
        longint      sa, sb;
        logic [63:0] p, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        hi = '0;
        lo = '0;
        case (op)
            2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; hi = p[63:32]; lo = p[31:0]; end
            2'b10: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0]; end
            end
            default: begin
                if (b == 0) begin hi = a; lo = '1; end
                else begin hi = a % b; lo = a / b; end
            end
        endcase
    endfunction

    // Called at a negedge with the unit idle. mode 1: start held and operands
    // scrambled during BUSY; mode 2: MTHI/MTLO coincident with DONE.
    task automatic do_op(input logic [1:0] op, input logic [W-1:0] a, b, exp_hi, exp_lo,
                         input int mode, input string nm);
        int cyc, lat;
        bit seen, bad;
        lat = op[1] ? W + 1 : MUL_LAT;
        chk({nm, " idle_stall"}, 64'(stall_o), 64'(0));
        start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
        #1 chk({nm, " launch_stall"}, 64'(stall_o), 64'(1));
        cyc = 0; seen = 0; bad = 0;
        while (!seen && cyc < 3 * W) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (mode != 1) start_i = 1'b0;
            else begin src_a_i = $urandom; src_b_i = $urandom; end
            if (done_o) seen = 1;
            else if (!busy_o || !stall_o) bad = 1;
        end
        start_i = 1'b0;
        chk({nm, " latency"}, seen ? 64'(cyc) : '1, 64'(lat));
        chk({nm, " busy_stall"}, 64'(bad), 64'(0));
        chk({nm, " done_no_stall"}, 64'(stall_o | busy_o), 64'(0));
        if (mode == 2) begin hi_we_i = 1'b1; lo_we_i = 1'b1; hilo_wdata_i = 32'h5a5a5a5a; end
        @(posedge clk); @(negedge clk);
        hi_we_i = 1'b0; lo_we_i = 1'b0;
        chk({nm, " done_pulse"}, 64'(done_o), 64'(0));
        chk({nm, " hi"}, 64'(hi_o), 64'(exp_hi));
        chk({nm, " lo"}, 64'(lo_o), 64'(exp_lo));
    endtask

    initial begin
        logic [1:0]   rop;
        logic [W-1:0] ra, rb, mh, ml;
        bit           spurious;

        vt[0] = '{2'b00, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 0};
        vt[1] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1};
        vt[2] = '{2'b11, 32'd100,      32'd7,        32'd2,        32'd14,       0};
        vt[3] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 0};
        vt[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 0};
        vt[5] = '{2'b11, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 0};
        vt[6] = '{2'b10, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 2};
        vt[7] = '{2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2};
        vt[8] = '{2'b10, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 0};
        vt[9] = '{2'b01, 32'd0,        32'h12345678, 32'h00000000, 32'h00000000, 0};

        resetn = 1'b0; start_i = 1'b0; cancel_i = 1'b0; hi_we_i = 1'b0; lo_we_i = 1'b0;
        op_i = '0; src_a_i = '0; src_b_i = '0; hilo_wdata_i = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy_o), 64'(0));
        chk("reset done", 64'(done_o), 64'(0));
        chk("reset hi", 64'(hi_o), 64'(0));
        chk("reset lo", 64'(lo_o), 64'(0));
        resetn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++)
            do_op(vt[i].op, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, vt[i].mode,
                  $sformatf("vec%0d", i));

        // MTLO mid-BUSY, then cancel with a coincident MTHI
        start_i = 1'b1; op_i = 2'b10; src_a_i = 32'd1000; src_b_i = 32'd3;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); @(negedge clk);
            start_i = 1'b0;
            if (c == 3) begin lo_we_i = 1'b1; hilo_wdata_i = 32'h1234; end
            if (c == 4) begin lo_we_i = 1'b0; chk("mtlo busy", 64'(lo_o), 64'h1234); end
        end
        cancel_i = 1'b1; hi_we_i = 1'b1; hilo_wdata_i = 32'hABCD;
        @(posedge clk); @(negedge clk);
        cancel_i = 1'b0; hi_we_i = 1'b0;
        chk("cancel busy", 64'(busy_o), 64'(0));
        chk("cancel done", 64'(done_o), 64'(0));
        chk("cancel mthi", 64'(hi_o), 64'hABCD);
        chk("cancel lo kept", 64'(lo_o), 64'h1234);
        do_op(2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 0, "post_cancel");

        // Let the unit idle: no stray completion may appear
        spurious = 0;
        repeat (W + 4) begin
            @(posedge clk); @(negedge clk);
            if (done_o || busy_o) spurious = 1;
        end
        chk("idle quiet", 64'(spurious), 64'(0));

        // Asynchronous reset mid-DIV
        start_i = 1'b1; op_i = 2'b10; src_a_i = 32'hFFFFFF9C; src_b_i = 32'd7;
        repeat (5) begin @(posedge clk); @(negedge clk); start_i = 1'b0; end
        resetn = 1'b0;
        #1;
        chk("rst busy", 64'(busy_o), 64'(0));
        chk("rst stall", 64'(stall_o), 64'(0));
        chk("rst hi", 64'(hi_o), 64'(0));
        chk("rst lo", 64'(lo_o), 64'(0));
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_op(2'b01, 32'd3, 32'd4, 32'd0, 32'd12, 0, "post_reset");

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 9))
                0: rb = '0;
                1: rb = '1;
                2: ra = 32'h80000000;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            model(rop, ra, rb, mh, ml);
            do_op(rop, ra, rb, mh, ml, 0, $sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
